// File: rtl/upg_loader_if.sv
// Byte-stream input and memory-write output bundle of the upgrade loader.
interface upg_loader_if;
  logic        start_i;
  logic [7:0]  rx_dat_i;
  logic        rx_vld_i;
  logic        upg_wen_o;
  logic [13:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output start_i, rx_dat_i, rx_vld_i,
    input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
  );

  modport slave (
    input  start_i, rx_dat_i, rx_vld_i,
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o
  );
endinterface

// File: rtl/upg_loader.sv
// Upgrade loader: parses a length-prefixed little-endian byte stream into
// 32-bit memory writes, with an inactivity timeout that aborts the session.
module upg_loader #(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_WORDS   = 16384
) (
  input  logic         upg_clk_i,
  input  logic         upg_rst_n_i,
  upg_loader_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYC);
  // err_o is registered, so fire one cycle early: ERR then shows on the
  // TIMEOUT_CYC-th idle cycle after the last accepted byte.
  localparam logic [CW-1:0] TMO_FIRE = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [15:0]   len_q, len_d;
  logic [14:0]   wcnt_q, wcnt_d;
  logic [1:0]    k_q, k_d;
  logic [23:0]   part_q, part_d;
  logic          last_q, last_d;
  logic          wen_q, wen_d;
  logic [13:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;

  logic        active, acc;
  logic [15:0] cnt_full;

  always_comb begin
    active   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    acc      = active && bus.rx_vld_i;
    cnt_full = {bus.rx_dat_i, len_q[7:0]};

    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    k_d     = k_q;
    part_d  = part_q;
    last_d  = last_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    if (acc) tmo_d = '0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start_i) begin
          state_d = LEN_LO;
          tmo_d   = '0;
          k_d     = '0;
          wcnt_d  = '0;
          last_d  = 1'b0;
        end
      end
      LEN_LO: begin
        if (acc) begin
          len_d[7:0] = bus.rx_dat_i;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (acc) begin
          len_d[15:8] = bus.rx_dat_i;
          if (cnt_full == 16'd0 || cnt_full > 16'(MAX_WORDS)) state_d = ERR;
          else                                                 state_d = DATA;
        end
      end
      DATA: begin
        if (acc) begin
          k_d = k_q + 2'd1;
          case (k_q)
            2'd0: part_d[7:0]   = bus.rx_dat_i;
            2'd1: part_d[15:8]  = bus.rx_dat_i;
            2'd2: part_d[23:16] = bus.rx_dat_i;
            default: begin
              // fourth byte: launch the write on the following cycle
              wen_d  = 1'b1;
              adr_d  = wcnt_q[13:0];
              dat_d  = {bus.rx_dat_i, part_q};
              wcnt_d = wcnt_q + 15'd1;
              last_d = (16'(wcnt_q) + 16'd1) == len_q;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    if (active && !acc && tmo_d >= TMO_FIRE) state_d = ERR;
    // a completed load wins over a coincident timeout
    if (state_q == DATA && wen_q && last_q) state_d = DONE;
  end

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      k_q     <= '0;
      part_q  <= '0;
      last_q  <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      k_q     <= k_d;
      part_q  <= part_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.upg_wen_o  = wen_q;
  assign bus.upg_adr_o  = adr_q;
  assign bus.upg_dat_o  = dat_q;
  assign bus.upg_done_o = (state_q == DONE);
  assign bus.busy_o     = active;
  assign bus.err_o      = (state_q == ERR);
endmodule

// File: doc/upg_loader.md
UPG_LOADER -- requirements
Module: upg_loader

Interface
REQ-001 Parameter TIMEOUT_CYC, default 2000000: idle cycles between accepted bytes (or after start) before abort.
REQ-002 Parameter MAX_WORDS, default 16384: largest legal word count, equal to the depth of the 14-bit word address space.
REQ-003 upg_clk_i  in  1  single clock; all logic is on its rising edge.
REQ-004 upg_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  one-cycle pulse that arms a load session.
REQ-006 rx_dat_i  in  8  received byte, valid only while rx_vld_i=1.
REQ-007 rx_vld_i  in  1  byte strobe; each high cycle carries exactly one byte, with no backpressure.
REQ-008 upg_wen_o  out  1  memory write strobe.
REQ-009 upg_adr_o  out  14  word address.
REQ-010 upg_dat_o  out  32  write data.
REQ-011 upg_done_o  out  1  load complete; memory returns to CPU ownership.
REQ-012 busy_o  out  1  session in progress.
REQ-013 err_o  out  1  session aborted.

Function
REQ-014 States are IDLE, LEN_LO, LEN_HI, DATA, DONE and ERR.
REQ-015 Stream format:
- Word count N as 2 bytes, little-endian.
- Then N words of 4 bytes each, little-endian: first byte goes to bits [7:0].
REQ-016 In IDLE, DONE and ERR, rx_vld_i bytes are ignored.
REQ-017 start_i in IDLE, DONE or ERR:
- Next state is LEN_LO.
- busy_o=1; upg_done_o=0; err_o=0.
- Timeout counter=0; byte index=0; address=0.
REQ-018 start_i in LEN_LO, LEN_HI or DATA is ignored.
REQ-019 LEN_LO captures count[7:0] on rx_vld_i, then moves to LEN_HI.
REQ-020 LEN_HI captures count[15:8] on rx_vld_i:
- If count==0 or count>MAX_WORDS, go to ERR.
- Otherwise go to DATA.
REQ-021 In DATA, each accepted byte is written into word bits [8k+7:8k], where k is the 2-bit byte index; k then increments modulo 4.
REQ-022 Write pulse timing:
- Trigger is the cycle the k=3 byte is accepted.
- On the next cycle, upg_wen_o=1 for exactly one cycle.
- During that cycle, upg_adr_o = current word address and upg_dat_o = the assembled word.
REQ-023 A byte accepted during the write-pulse cycle becomes byte 0 of the next word; no byte is lost at full rate (rx_vld_i high every cycle).
REQ-024 Address increments by 1 after each write and never wraps, because N≤MAX_WORDS.
REQ-025 After the Nth write pulse:
- Next cycle: state DONE, upg_done_o=1, busy_o=0.
- upg_done_o stays high until start_i or reset.
REQ-026 upg_adr_o and upg_dat_o hold their last values when upg_wen_o=0.
REQ-027 Timeout counter:
- Cleared on start_i and on every accepted byte in LEN_LO, LEN_HI and DATA.
- Otherwise increments, saturating.
- Reaching TIMEOUT_CYC in LEN_LO, LEN_HI or DATA moves to ERR.
REQ-028 Entering ERR:
- err_o=1, busy_o=0, upg_done_o=0.
- Partial word is discarded; no further upg_wen_o.
- A write pulse already due in that cycle still completes.
REQ-029 If the timeout limit and an accepted byte land in the same cycle, the byte wins and the counter clears.
REQ-030 Counter width is ceil(log2(TIMEOUT_CYC+1)) bits.

Reset
REQ-031 While upg_rst_n_i=0, the block is immediately in IDLE and all outputs are 0: upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o.
REQ-032 Reset mid-session discards the count, the partial word and the address; no write pulse is issued after release.
REQ-033 After release, the block waits in IDLE for start_i with upg_done_o=0.

Verification
REQ-034 Single word: reset, start_i, bytes 01 00 EF BE AD DE:
- One upg_wen_o pulse with adr=0 and dat=32'hDEADBEEF, one cycle after the DE byte.
- upg_done_o=1 on the following cycle.
REQ-035 Full rate: N=3 (03 00), 12 bytes on consecutive cycles:
- Three pulses at adr 0, 1, 2, spaced exactly 4 cycles apart.
- Words match the input; done follows the third pulse.
REQ-036 Bad counts:
- Bytes 00 00 -> err_o=1, zero pulses.
- Bytes 01 40 (16385) -> err_o=1, zero pulses.
REQ-037 Timeout (TIMEOUT_CYC=16): N=1, then 2 data bytes, then silence -> err_o=1 exactly 16 cycles after the last byte, with no pulse.
REQ-038 Reset mid-word: assert upg_rst_n_i after 2 data bytes:
- All outputs 0 immediately.
- After release, start_i and a fresh single-word load write adr 0 with the new data only.
REQ-039 start_i while busy_o=1 is ignored; after DONE, a new start_i clears upg_done_o on the next cycle and a second load restarts at adr 0.
